// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the MIPS core datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath select and strobe from the current state.
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions park the
// FSM in TRAP and raise illegal_instr; otherwise they retire as a NOP.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC += 4 when memory is ready
// DECODE   | decode opcode/funct, precompute branch target into ALUOut
// EXEC_R   | rs op rt for R-type
// EXEC_I   | rs op imm for addiu/ori/lui
// MEM_ADDR | rs + sign-extended imm for lw/sw
// MEM_RD   | load data read, waits on mem_ready
// MEM_WR   | store data write, waits on mem_ready
// WB_R     | write ALUOut to rd
// WB_I     | write ALUOut to rt
// WB_MEM   | write MDR to rt
// BRANCH   | beq compare, load PC from ALUOut when equal
// JUMP     | load PC with jump target
// TRAP     | illegal instruction, parked until reset (trap build only)

module mc_ctrl_fsm #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            ir_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            iord,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            ext_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_ctrl,
    output logic [1:0]      pc_src,
    output logic [ST_W-1:0] state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , output logic          illegal_instr
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t     state_q, state_d;
    logic       funct_ok;
    logic [2:0] r_alu;
    logic       pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;

    // Map R-type funct onto an ALU operation and flag unsupported encodings.
    always_comb begin
        funct_ok = 1'b1;
        r_alu    = ALU_ADD;
        case (funct)
            6'h21:   r_alu = ALU_ADD;
            6'h23:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h2A:   r_alu = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state selection and per-state datapath controls.
    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        iord          = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctrl      = ALU_ADD;
        pc_src        = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_d = funct_ok ? S_EXEC_R : S_TRAP;
`else
                        state_d = funct_ok ? S_EXEC_R : S_FETCH;
`endif
                    end
                    OP_ADDIU, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:                  state_d = S_TRAP;
`else
                    // PC already advanced in FETCH, so this retires as a NOP.
                    default:                  state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = r_alu;
                state_d   = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_ORI)      alu_ctrl = ALU_OR;
                else if (opcode == OP_LUI) alu_ctrl = ALU_LUI;
                else                       alu_ctrl = ALU_ADD;
                state_d = S_WB_I;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_WB_R: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                state_d       = S_FETCH;
            end
            S_WB_I: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_ctrl     = ALU_SUB;
                pc_src       = 2'b01;
                pc_write_raw = alu_zero;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are forced low while reset is held so nothing partial retires.
    always_comb begin
        pc_write  = pc_write_raw  & ~rst;
        ir_write  = ir_write_raw  & ~rst;
        mem_read  = mem_read_raw  & ~rst;
        mem_write = mem_write_raw & ~rst;
        reg_write = reg_write_raw & ~rst;
    end

    // Extender mode follows the decoded opcode in every state past FETCH.
    always_comb begin
        ext_op = 1'b0;
        if (state_q != S_FETCH) begin
            case (opcode)
                OP_ADDIU, OP_LW, OP_SW, OP_BEQ: ext_op = 1'b1;
                default:                        ext_op = 1'b0;
            endcase
        end
    end

    // State register with asynchronous return to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign state = ST_W'(state_q);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
    logic       reg_dst, mem_to_reg, ext_op, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int checks = 0;
    int errors = 0;

    mc_ctrl_fsm #(.ST_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ext_op(ext_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .state(state)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , .illegal_instr(illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then let combinational outputs settle mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;
        #3;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_mem_read", 8'(mem_read), 8'd0);
        chk("rst_pc_write", 8'(pc_write), 8'd0);
        cyc(); cyc();
        rst = 1'b0; #1;

        // fetch stall: mem_ready low holds FETCH without IR/PC writes
        chk("fetch_stall_mem_read", 8'(mem_read), 8'd1);
        chk("fetch_stall_ir_write", 8'(ir_write), 8'd0);
        cyc();
        chk("fetch_stall_state", 8'(state), 8'd0);

        // addiu: 0,1,3,8
        opcode = 6'h09; mem_ready = 1'b1; #1;
        chk("addiu_f_ir_write", 8'(ir_write), 8'd1);
        chk("addiu_f_pc_write", 8'(pc_write), 8'd1);
        chk("addiu_f_srcb", 8'(alu_src_b), 8'd1);
        chk("addiu_f_iord", 8'(iord), 8'd0);
        cyc();
        chk("addiu_d_state", 8'(state), 8'd1);
        chk("addiu_d_srcb", 8'(alu_src_b), 8'd3);
        chk("addiu_d_ext", 8'(ext_op), 8'd1);
        cyc();
        chk("addiu_e_state", 8'(state), 8'd3);
        chk("addiu_e_srcb", 8'(alu_src_b), 8'd2);
        chk("addiu_e_srca", 8'(alu_src_a), 8'd1);
        chk("addiu_e_alu", 8'(alu_ctrl), 8'd0);
        chk("addiu_e_ext", 8'(ext_op), 8'd1);
        cyc();
        chk("addiu_wb_state", 8'(state), 8'd8);
        chk("addiu_wb_reg_write", 8'(reg_write), 8'd1);
        chk("addiu_wb_reg_dst", 8'(reg_dst), 8'd0);
        chk("addiu_wb_pc_write", 8'(pc_write), 8'd0);
        cyc();
        chk("addiu_done_state", 8'(state), 8'd0);

        // ori
        opcode = 6'h0D;
        cyc(); cyc();
        chk("ori_e_state", 8'(state), 8'd3);
        chk("ori_e_ext", 8'(ext_op), 8'd0);
        chk("ori_e_alu", 8'(alu_ctrl), 8'd3);
        cyc(); cyc();

        // lui
        opcode = 6'h0F;
        cyc(); cyc();
        chk("lui_e_alu", 8'(alu_ctrl), 8'd5);
        cyc(); cyc();

        // slt R-type
        opcode = 6'h00; funct = 6'h2A;
        cyc();
        chk("slt_d_ext", 8'(ext_op), 8'd0);
        cyc();
        chk("slt_e_state", 8'(state), 8'd2);
        chk("slt_e_alu", 8'(alu_ctrl), 8'd4);
        chk("slt_e_srcb", 8'(alu_src_b), 8'd0);
        cyc();
        chk("slt_wb_state", 8'(state), 8'd7);
        chk("slt_wb_reg_dst", 8'(reg_dst), 8'd1);
        chk("slt_wb_reg_write", 8'(reg_write), 8'd1);
        cyc();

        // subu
        funct = 6'h23;
        cyc(); cyc();
        chk("subu_e_alu", 8'(alu_ctrl), 8'd1);
        cyc(); cyc();

        // lw with 3 stall cycles in MEM_RD: total 8 cycles
        opcode = 6'h23;
        cyc();
        cyc();
        chk("lw_ma_state", 8'(state), 8'd4);
        chk("lw_ma_ext", 8'(ext_op), 8'd1);
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mr_stall_state", 8'(state), 8'd5);
            chk("lw_mr_stall_mem_read", 8'(mem_read), 8'd1);
            chk("lw_mr_stall_iord", 8'(iord), 8'd1);
            cyc();
        end
        mem_ready = 1'b1; #1;
        chk("lw_mr_last_state", 8'(state), 8'd5);
        chk("lw_mr_last_mem_write", 8'(mem_write), 8'd0);
        cyc();
        chk("lw_wb_state", 8'(state), 8'd9);
        chk("lw_wb_mem_to_reg", 8'(mem_to_reg), 8'd1);
        chk("lw_wb_reg_write", 8'(reg_write), 8'd1);
        chk("lw_wb_mem_read", 8'(mem_read), 8'd0);
        cyc();
        chk("lw_done_state", 8'(state), 8'd0);

        // sw
        opcode = 6'h2B;
        cyc(); cyc(); cyc();
        chk("sw_mw_state", 8'(state), 8'd6);
        chk("sw_mw_mem_write", 8'(mem_write), 8'd1);
        chk("sw_mw_mem_read", 8'(mem_read), 8'd0);
        chk("sw_mw_iord", 8'(iord), 8'd1);
        cyc();
        chk("sw_done_state", 8'(state), 8'd0);

        // beq taken
        opcode = 6'h04; alu_zero = 1'b1;
        cyc(); cyc();
        chk("beq1_state", 8'(state), 8'd10);
        chk("beq1_pc_write", 8'(pc_write), 8'd1);
        chk("beq1_pc_src", 8'(pc_src), 8'd1);
        chk("beq1_alu", 8'(alu_ctrl), 8'd1);
        cyc();
        chk("beq1_done_state", 8'(state), 8'd0);

        // beq not taken
        alu_zero = 1'b0;
        cyc(); cyc();
        chk("beq0_state", 8'(state), 8'd10);
        chk("beq0_pc_write", 8'(pc_write), 8'd0);
        cyc();
        chk("beq0_done_state", 8'(state), 8'd0);

        // j
        opcode = 6'h02;
        cyc(); cyc();
        chk("j_state", 8'(state), 8'd11);
        chk("j_pc_write", 8'(pc_write), 8'd1);
        chk("j_pc_src", 8'(pc_src), 8'd2);
        cyc();

        // reset in the middle of lw MEM_RD
        opcode = 6'h23; mem_ready = 1'b1;
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        chk("rlw_pre_state", 8'(state), 8'd5);
        rst = 1'b1; #1;
        chk("rlw_state", 8'(state), 8'd0);
        chk("rlw_mem_read", 8'(mem_read), 8'd0);
        chk("rlw_reg_write", 8'(reg_write), 8'd0);
        mem_ready = 1'b1;
        cyc();
        chk("rlw_hold_state", 8'(state), 8'd0);
        chk("rlw_hold_ir_write", 8'(ir_write), 8'd0);
        rst = 1'b0; #1;
        chk("rlw_rel_mem_read", 8'(mem_read), 8'd1);
        chk("rlw_rel_iord", 8'(iord), 8'd0);
        chk("rlw_rel_ir_write", 8'(ir_write), 8'd1);

        // illegal opcode
        opcode = 6'h3F;
        cyc();
        chk("ill_d_state", 8'(state), 8'd1);
        cyc();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk("ill_trap_state", 8'(state), 8'd12);
        chk("ill_trap_flag", 8'(illegal_instr), 8'd1);
        chk("ill_trap_mem_read", 8'(mem_read), 8'd0);
        cyc(); cyc();
        chk("ill_trap_hold_state", 8'(state), 8'd12);
        chk("ill_trap_hold_flag", 8'(illegal_instr), 8'd1);
`else
        chk("ill_nop_state", 8'(state), 8'd0);
        chk("ill_nop_reg_write", 8'(reg_write), 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
